fperm_tbl_loader: RTL and testbench

FPERM_TBL_LOADER -- requirements
Module: fperm_tbl_loader

---
 rtl/fperm_tbl_loader.sv | 140 ++++++++++++++
 tb/tb_fperm_tbl_loader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fperm_tbl_loader.sv
// fperm_tbl_loader: streams DEPTH words into a table port.
// Define FPERM_TBL_VERIFY_EN to add read-back and XOR signature check.
module fperm_tbl_loader #(
  parameter int         DEPTH  = 8,
  parameter int         RD_LAT = 2,
  parameter logic [1:0] FTYPE  = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [67:0] in_data,
  output logic        tbl_write,
  output logic        tbl_read,
  output logic [2:0]  tbl_xtra,
  output logic [67:0] tbl_A,
  output logic [67:0] tbl_B,
  input  logic [67:0] tbl_rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    DRAIN,
    FIN
  } state_t;

  localparam logic [2:0] LAST = 3'(DEPTH - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [67:0] wsig;
  logic        xfer;
  logic        rd;
  logic        acc;

  assign xfer      = (state == LOAD) && in_valid;
  assign acc       = xfer || rd;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign in_ready  = (state == LOAD);
  assign tbl_write = xfer;
  assign tbl_read  = rd;
  assign tbl_xtra  = acc ? idx : 3'd0;
  assign tbl_A     = acc ? {FTYPE, 66'b0} : 68'b0;
  assign tbl_B     = xfer ? in_data : 68'b0;

`ifdef FPERM_TBL_VERIFY_EN
  logic [RD_LAT-1:0] vld;
  logic [67:0]       rsig;
  logic              err_q;

  assign rd  = (state == VERIFY);
  assign err = err_q;
`else
  logic unused_rd;

  assign rd        = 1'b0;
  assign err       = 1'b0;
  assign unused_rd = ^tbl_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      wsig  <= '0;
`ifdef FPERM_TBL_VERIFY_EN
      vld   <= '0;
      rsig  <= '0;
      err_q <= 1'b0;
`endif
    end else begin
`ifdef FPERM_TBL_VERIFY_EN
      // vld[k] marks a read issued k+1 cycles ago
      vld[0] <= rd;
      for (int i = 1; i < RD_LAT; i++)
        vld[i] <= vld[i-1];
      if (vld[RD_LAT-1])
        rsig <= rsig ^ tbl_rdata;
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            idx   <= '0;
            wsig  <= '0;
`ifdef FPERM_TBL_VERIFY_EN
            rsig  <= '0;
            err_q <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            wsig <= wsig ^ in_data;
            if (idx == LAST) begin
              idx   <= '0;
`ifdef FPERM_TBL_VERIFY_EN
              state <= VERIFY;
`else
              state <= FIN;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
`ifdef FPERM_TBL_VERIFY_EN
        VERIFY: begin
          if (idx == LAST) begin
            idx   <= '0;
            state <= DRAIN;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DRAIN: begin
          if (vld == '0) begin
            err_q <= (rsig != wsig);
            state <= FIN;
          end
        end
`endif
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fperm_tbl_loader.sv
// tb_fperm_tbl_loader: scoreboard bench for fperm_tbl_loader.
// Table model returns written data RD_LAT cycles after a read.
module tb_fperm_tbl_loader;

  localparam int         DEPTH  = 8;
  localparam int         RD_LAT = 2;
  localparam logic [1:0] FTYPE  = 2'b10;

  localparam logic [1:0] K_I = 2'd0;
  localparam logic [1:0] K_W = 2'd1;
  localparam logic [1:0] K_R = 2'd2;
  localparam logic [1:0] K_D = 2'd3;

  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] idx;
    logic [67:0] data;
    logic [31:0] c;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [67:0] in_data = '0;
  logic        in_ready;
  logic        tbl_write;
  logic        tbl_read;
  logic [2:0]  tbl_xtra;
  logic [67:0] tbl_A;
  logic [67:0] tbl_B;
  logic [67:0] tbl_rdata;
  logic        busy;
  logic        done;
  logic        err;

  fperm_tbl_loader #(
    .DEPTH (DEPTH),
    .RD_LAT(RD_LAT),
    .FTYPE (FTYPE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tbl_write(tbl_write),
    .tbl_read (tbl_read),
    .tbl_xtra (tbl_xtra),
    .tbl_A    (tbl_A),
    .tbl_B    (tbl_B),
    .tbl_rdata(tbl_rdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_chk = 0;
  int  n_pass = 0;
  int  proto_bad = 0;
  bit  corrupt = 1'b0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  logic [67:0] mem [DEPTH];
  logic [67:0] pipe [RD_LAT];

  always @(posedge clk) begin
    if (tbl_write) mem[tbl_xtra] <= tbl_B;
    if (tbl_read)
      pipe[0] <= mem[tbl_xtra] ^
        ((corrupt && tbl_xtra == 3'd3) ? 68'h1 : 68'h0);
    else
      pipe[0] <= 68'h5_A5A5_0000_0000_C3C3;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign tbl_rdata = pipe[RD_LAT-1];

  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    ev_t m;
    #1;
    if (tbl_write) begin
      m = {K_W, 32'(tbl_xtra), tbl_B, 32'(cyc)};
      obs_q.push_back(m);
    end
    if (tbl_read) begin
      m = {K_R, 32'(tbl_xtra), 68'h0, 32'(cyc)};
      obs_q.push_back(m);
    end
    if (done) begin
      m = {K_D, 32'h0, 68'(err), 32'(cyc)};
      obs_q.push_back(m);
    end
    if (prev_busy && !busy) begin
      m = {K_I, 32'h0, 68'h0, 32'(cyc)};
      obs_q.push_back(m);
    end
    prev_busy = busy;
    if (tbl_write && tbl_read) proto_bad++;
    if (!tbl_write && tbl_B != 68'h0) proto_bad++;
    if ((tbl_write || tbl_read) && tbl_A != {FTYPE, 66'b0}) proto_bad++;
    if (!busy && (in_ready || tbl_write || tbl_read || done)) proto_bad++;
    if (in_ready && (tbl_read || done)) proto_bad++;
  end

  task automatic run(input bit rnd, input bit gap, input bit poke);
    logic [67:0] w;
    ev_t e;
    int n, t, last, dc;
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    t = 0;
    last = cyc;
    while (n < DEPTH && t < 100) begin
      w = rnd ? {4'($urandom), $urandom, $urandom} : 68'(n + 1);
      in_valid = !gap || (t % 2 == 0);
      in_data = w;
      start = poke && (t == 2);
      if (in_valid) begin
        e = {K_W, 32'(n), w, 32'(cyc)};
        exp_q.push_back(e);
        last = cyc;
        n++;
      end
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    in_data = '0;
    start = 1'b0;
`ifdef FPERM_TBL_VERIFY_EN
    for (int i = 0; i < DEPTH; i++) begin
      e = {K_R, 32'(i), 68'h0, 32'(last + 1 + i)};
      exp_q.push_back(e);
    end
    dc = last + DEPTH + RD_LAT + 2;
`else
    dc = last + 1;
`endif
    e = {K_D, 32'h0, 68'(corrupt), 32'(dc)};
    exp_q.push_back(e);
    e = {K_I, 32'h0, 68'h0, 32'(dc + 1)};
    exp_q.push_back(e);
    while (cyc < dc && t < 200) begin
      @(negedge clk);
      t++;
    end
    start = poke;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 68'hF_FFFF_FFFF_FFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({busy, done, err, in_ready, tbl_write, tbl_read} !== 6'b0)
      $display("FAIL reset_ctl got %b exp 000000",
               {busy, done, err, in_ready, tbl_write, tbl_read});
    else n_pass++;
    n_chk++;
    if ({tbl_xtra, tbl_A, tbl_B} !== '0)
      $display("FAIL reset_bus got %h exp 0", {tbl_xtra, tbl_A, tbl_B});
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    @(negedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_idle busy got %b exp 0", busy);
    else n_pass++;
  endtask

  task automatic test_load_basic();
    ev_t e, o;
    run(1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_chk++;
      if (o !== e) $display("FAIL basic_ev got %h exp %h", o, e);
      else n_pass++;
    end
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL basic_extra got %0d exp 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_gaps();
    ev_t e, o;
    run(1'b1, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_chk++;
      if (o !== e) $display("FAIL gaps_ev got %h exp %h", o, e);
      else n_pass++;
    end
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL gaps_extra got %0d exp 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    ev_t e, o;
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1;
      in_data = {4'(n), 64'hABC0_1234_0000_0ABC};
      e = {K_W, 32'(n), in_data, 32'(cyc)};
      exp_q.push_back(e);
      @(negedge clk);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    e = {K_I, 32'h0, 68'h0, 32'(cyc + 1)};
    exp_q.push_back(e);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 68'hF00D;
    #1;
    n_chk++;
    if ({busy, tbl_write, in_ready} !== 3'b000)
      $display("FAIL midrst_out got %b exp 000", {busy, tbl_write, in_ready});
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_chk++;
      if (o !== e) $display("FAIL midrst_ev got %h exp %h", o, e);
      else n_pass++;
    end
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL midrst_extra got %0d exp 0", obs_q.size());
    else n_pass++;
    run(1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_chk++;
      if (o !== e) $display("FAIL rerun_ev got %h exp %h", o, e);
      else n_pass++;
    end
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL rerun_extra got %0d exp 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    ev_t e, o;
    run(1'b1, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_chk++;
      if (o !== e) $display("FAIL poke_ev got %h exp %h", o, e);
      else n_pass++;
    end
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL poke_extra got %0d exp 0", obs_q.size());
    else n_pass++;
    #1;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL poke_busy got %b exp 0", busy);
    else n_pass++;
  endtask

`ifdef FPERM_TBL_VERIFY_EN
  task automatic test_verify_ok();
    ev_t e, o;
    corrupt = 1'b0;
    run(1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_chk++;
      if (o !== e) $display("FAIL vok_ev got %h exp %h", o, e);
      else n_pass++;
    end
    n_chk++;
    if (obs_q.size() != 0)
      $display("FAIL vok_extra got %0d exp 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_verify_corrupt();
    ev_t e, o;
    corrupt = 1'b1;
    run(1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
      n_chk++;
      if (o !== e) $display("FAIL vbad_ev got %h exp %h", o, e);
      else n_pass++;
    end
    repeat (4) @(negedge clk);
    #1;
    n_chk++;
    if (err !== 1'b1) $display("FAIL err_sticky got %b exp 1", err);
    else n_pass++;
    corrupt = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_chk++;
    if ({busy, err} !== 2'b10)
      $display("FAIL err_clear got %b exp 10", {busy, err});
    else n_pass++;
    for (int n = 0; n < DEPTH; n++) begin
      in_valid = 1'b1;
      in_data = 68'(n * 7 + 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data = '0;
    repeat (DEPTH + RD_LAT + 6) @(negedge clk);
    #1;
    n_chk++;
    if ({busy, err} !== 2'b00)
      $display("FAIL err_after got %b exp 00", {busy, err});
    else n_pass++;
  endtask
`endif

  task automatic test_protocol();
    n_chk++;
    if (proto_bad !== 0)
      $display("FAIL protocol got %0d violations exp 0", proto_bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_gaps();
    test_reset_midrun();
    test_start_ignored();
`ifdef FPERM_TBL_VERIFY_EN
    test_verify_ok();
    test_verify_corrupt();
`endif
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
